// File: rtl/cla_mp_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_mp_sequencer_if
// Brief    : Operand/result handshakes and shared 8-bit adder slice port.
// Revision : 1.0
// ============================================================================
interface cla_mp_sequencer_if #(
    parameter int NBYTES = 4
);
    logic                  start_valid;
    logic                  start_ready;
    logic [8*NBYTES-1:0]   op_a;
    logic [8*NBYTES-1:0]   op_b;
    logic                  sub;
    logic [7:0]            add_a;
    logic [7:0]            add_b;
    logic                  add_cin;
    logic [7:0]            add_sum;
    logic                  add_cout;
    logic                  res_valid;
    logic                  res_ready;
    logic [8*NBYTES-1:0]   result;
    logic                  carry_out;
    logic                  overflow;

    modport slave (
        input  start_valid, op_a, op_b, sub, add_sum, add_cout, res_ready,
        output start_ready, add_a, add_b, add_cin, res_valid, result, carry_out, overflow
    );

    modport master (
        output start_valid, op_a, op_b, sub, add_sum, add_cout, res_ready,
        input  start_ready, add_a, add_b, add_cin, res_valid, result, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/cla_mp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_mp_sequencer
// Brief    : Multi-precision add/sub controller time-sharing one 8-bit adder.
// Revision : 1.0
// ============================================================================
module cla_mp_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    cla_mp_sequencer_if.slave   bus
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_sub;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;

    always_comb begin
        w_a_byte = r_a[8*int'(r_idx) +: 8];
        w_b_byte = r_b[8*int'(r_idx) +: 8];
    end

    // Adder inputs come only from registered state, so no input reaches an output combinationally.
    always_comb begin
        bus.add_a   = 8'd0;
        bus.add_b   = 8'd0;
        bus.add_cin = 1'b0;
        if (r_state == S_RUN) begin
            bus.add_a   = w_a_byte;
            bus.add_b   = w_b_byte ^ {8{r_sub}};
            bus.add_cin = r_carry;
        end
    end

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.carry_out   = r_carry_out;
    assign bus.overflow    = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_sub   <= bus.sub;
                        // Subtraction is A + ~B + 1: the +1 enters as the first carry-in.
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[8*int'(r_idx) +: 8] <= bus.add_sum;
                    r_carry <= bus.add_cout;
                    if (r_idx == C_LAST_IDX) begin
                        r_carry_out <= bus.add_cout;
                        r_overflow  <= (bus.add_a[7] == bus.add_b[7]) &&
                                       (bus.add_sum[7] != bus.add_a[7]);
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
